// File: rtl/fpu_multicycle_sched_if.sv
// Handshake bundle between decode/issue and the iterative FPU scheduler.
// Covers request, hazard query, unit control and completion signals.
interface fpu_multicycle_sched_if #(
    parameter int ISSUE_NUM = 2
);
    logic                   flush;
    logic [ISSUE_NUM-1:0]   req_valid;
    logic [ISSUE_NUM-1:0]   req_sqrt;
    logic [ISSUE_NUM*5-1:0] req_fd;
    logic [ISSUE_NUM-1:0]   req_fcsr_we;
    logic [ISSUE_NUM-1:0]   req_ready;
    logic [ISSUE_NUM*5-1:0] query_fs1;
    logic [ISSUE_NUM*5-1:0] query_fs2;
    logic [ISSUE_NUM*2-1:0] query_fs_en;
    logic [ISSUE_NUM-1:0]   query_fcsr_rd;
    logic [ISSUE_NUM-1:0]   hazard_stall;
    logic                   unit_start;
    logic                   unit_sqrt;
    logic                   unit_slot;
    logic                   done_valid;
    logic [4:0]             done_fd;
    logic                   done_fcsr_we;

    modport master (
        output flush, req_valid, req_sqrt, req_fd, req_fcsr_we,
        output query_fs1, query_fs2, query_fs_en, query_fcsr_rd,
        input  req_ready, hazard_stall,
        input  unit_start, unit_sqrt, unit_slot,
        input  done_valid, done_fd, done_fcsr_we
    );

    modport slave (
        input  flush, req_valid, req_sqrt, req_fd, req_fcsr_we,
        input  query_fs1, query_fs2, query_fs_en, query_fcsr_rd,
        output req_ready, hazard_stall,
        output unit_start, unit_sqrt, unit_slot,
        output done_valid, done_fd, done_fcsr_we
    );
endinterface

// File: rtl/fpu_multicycle_sched.sv
// Scheduler for the shared iterative DIV.S/SQRT.S unit: in-order
// arbitration, busy countdown and RAW stalls against the pending result.
module fpu_multicycle_sched #(
    parameter int ISSUE_NUM = 2,
    parameter int DIV_LAT   = 10,
    parameter int SQRT_LAT  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_multicycle_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [5:0]           lat_m1;
    logic                 first_q;
    logic [4:0]           pend_fd_q;
    logic                 pend_fcsr_q;
    logic                 sqrt_q;
    logic                 slot_q;
    logic                 accept;
    logic                 sel;
    logic [ISSUE_NUM-1:0] ready;
    logic [ISSUE_NUM-1:0] haz;

    assign sel    = ~bus.req_valid[0];
    assign lat_m1 = bus.req_sqrt[sel] ? 6'(SQRT_LAT - 1)
                                      : 6'(DIV_LAT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = '0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Slot 1 is younger and only goes when slot 0 is silent.
                if (!bus.flush && !rst) begin
                    ready[0] = bus.req_valid[0];
                    ready[1] = bus.req_valid[1] & ~bus.req_valid[0];
                end
                accept = |ready;
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = lat_m1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = DONE;
                    cnt_d   = 6'd0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        haz = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            haz[i] = (state_q != IDLE) &&
                     ((bus.query_fs_en[2*i]   &&
                       bus.query_fs1[5*i +: 5] == pend_fd_q) ||
                      (bus.query_fs_en[2*i+1] &&
                       bus.query_fs2[5*i +: 5] == pend_fd_q) ||
                      (bus.query_fcsr_rd[i] && pend_fcsr_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            first_q     <= 1'b0;
            pend_fd_q   <= 5'd0;
            pend_fcsr_q <= 1'b0;
            sqrt_q      <= 1'b0;
            slot_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= accept;
            if (accept) begin
                pend_fd_q   <= sel ? bus.req_fd[9:5] : bus.req_fd[4:0];
                pend_fcsr_q <= bus.req_fcsr_we[sel];
                sqrt_q      <= bus.req_sqrt[sel];
                slot_q      <= sel;
            end
        end
    end

    assign bus.req_ready    = ready;
    assign bus.hazard_stall = haz;
    assign bus.unit_start   = (state_q == BUSY) && first_q;
    assign bus.unit_sqrt    = sqrt_q;
    assign bus.unit_slot    = slot_q;
    assign bus.done_valid   = (state_q == DONE);
    assign bus.done_fd      = (state_q == DONE) ? pend_fd_q : 5'd0;
    assign bus.done_fcsr_we = (state_q == DONE) && pend_fcsr_q;

endmodule

// File: doc/fpu_multicycle_sched.md
Name: fpu_multicycle_sched

Overview:
- Issue-side scheduler for the shared iterative FPU unit that executes DIV.S and SQRT.S.
- Arbitrates between the two issue slots and sequences the unit through start, count and done.
- Holds the single in-flight destination register and FCSR-write flag, and raises per-slot decode stalls on RAW hazards against that pending result.
- Stalls are needed because the result is not present in any exec, dcache, mem or wb stage until the unit completes.
- Sits beside the decode-stage FPU operand forwarding logic.

Parameters:
- ISSUE_NUM, 2, number of issue slots. Only the value 2 is supported.
- DIV_LAT, 10, busy cycles for a divide. Legal range 1..63.
- SQRT_LAT, 14, busy cycles for a square root. Legal range 1..63.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; cancels new acceptance only
- req_valid  in  ISSUE_NUM  slot i presents a multicycle FPU op
- req_sqrt  in  ISSUE_NUM  1 = SQRT.S, 0 = DIV.S
- req_fd  in  ISSUE_NUM*5  destination FPR per slot
- req_fcsr_we  in  ISSUE_NUM  op updates FCSR flags
- req_ready  out  ISSUE_NUM  slot i accepted this cycle
- query_fs1  in  ISSUE_NUM*5  decode source fs1 per slot
- query_fs2  in  ISSUE_NUM*5  decode source fs2 per slot
- query_fs_en  in  ISSUE_NUM*2  per-slot valid bits for fs1 and fs2
- query_fcsr_rd  in  ISSUE_NUM  slot reads FCSR (CFC1, BC1x, MOVF/MOVT)
- hazard_stall  out  ISSUE_NUM  decode must stall slot i
- unit_start  out  1  one-cycle start pulse to the unit
- unit_sqrt  out  1  operation select, valid with unit_start
- unit_slot  out  1  slot whose operands feed the unit
- done_valid  out  1  result is ready to enter the writeback request this cycle
- done_fd  out  5  destination FPR of the result
- done_fcsr_we  out  1  result carries FCSR flags

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; cnt=0; pend_fd=0; pend_fcsr=0; all outputs 0. Reset mid-operation aborts to IDLE with no done_valid.
- States:
  - IDLE: no operation in flight.
  - BUSY: the unit is counting down.
  - DONE: the result is presented for one cycle.
- Acceptance (combinational, IDLE only, and only when flush=0):
  - req_ready[0] = req_valid[0].
  - req_ready[1] = req_valid[1] & ~req_valid[0]. Program order is kept: the younger slot 1 never overtakes slot 0.
  - Both slots requesting in the same cycle: accept slot 0; slot 1 retries after DONE.
- On acceptance at cycle T, the following registers are captured:
  - pend_fd, pend_fcsr, unit_slot and unit_sqrt;
  - cnt = LAT-1, where LAT = SQRT_LAT if req_sqrt else DIV_LAT;
  - state becomes BUSY at T+1.
- BUSY:
  - unit_start=1 only in the first BUSY cycle (T+1).
  - cnt decrements each cycle.
  - When cnt==0, the next state is DONE.
- DONE:
  - done_valid=1, with done_fd=pend_fd and done_fcsr_we=pend_fcsr, for exactly one cycle.
  - The next state is IDLE.
  - done_valid is therefore first seen at cycle T+LAT+1.
  - The earliest next acceptance is T+LAT+2.
- hazard_stall[i] is combinational. It is asserted when state != IDLE and any of the following holds:
  - query_fs_en[i][0] & (query_fs1[i]==pend_fd);
  - query_fs_en[i][1] & (query_fs2[i]==pend_fd);
  - query_fcsr_rd[i] & pend_fcsr.
- hazard_stall is 0 in IDLE, including the cycle in which an op is being accepted. An instruction issued together with the op is handled by the downstream in-order dependency rules.
- FPR 0 is not special: matches on register 0 still stall.
- flush:
  - In IDLE, flush suppresses acceptance (req_ready=0).
  - In BUSY or DONE, flush has no effect, because accepted ops are already committed.
- Errors: none. Out-of-range LAT is a static configuration error and is not checked at run time.

Test Plan:
- Divide: slot 0 issues DIV.S with fd=5 at T, DIV_LAT=10 -> unit_start and unit_sqrt=0 at T+1; done_valid=1 with done_fd=5 at T+11 only; IDLE at T+12.
- Square root: slot 1 alone issues SQRT.S with fd=31 and fcsr_we=1 -> req_ready=01b→10b, i.e. req_ready[1]=1; unit_slot=1; done_valid at T+15 with done_fcsr_we=1.
- Simultaneous requests: req_valid=11b in IDLE -> req_ready=01b; slot 1 is held until IDLE, then accepted at T+12 with DIV_LAT=10.
- Hazards:
  - pending fd=7; query_fs2[0]=7 with enable set -> hazard_stall[0]=1 through the DONE cycle, 0 in the following cycle;
  - query_fs1[1]=7 with enable clear -> hazard_stall[1]=0;
  - query_fcsr_rd=1 with pend_fcsr=1 -> stall.
- Flush: flush=1 with req_valid=01b in IDLE -> req_ready=0 and state stays IDLE; flush=1 during BUSY -> done_valid still occurs on schedule.
- Reset: rst asserted at the third BUSY cycle -> IDLE next cycle, no done_valid, hazard_stall=0; a new request is accepted in the cycle after rst deasserts.
